// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Holds opcode constants and MEM-stage FSM encoding.
package pipe_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LOAD  = 5'b01010;
    localparam logic [4:0] OP_STORE = 5'b01011;

    typedef enum logic {
        IDLE,
        REQ
    } mem_state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// MEM stage bus bundle.
// Carries the EX/MEM input, the data-memory port and the MEM/WB output.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);

    logic              InValid;
    logic [4:0]        OpCode;
    logic [6:0]        RdOut;
    logic [DATA_W-1:0] AluResult;
    logic [DATA_W-1:0] StoreData;
    logic              Stall;
    logic              MemReq;
    logic              MemWe;
    logic [DATA_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemAck;
    logic [DATA_W-1:0] MemRData;
    logic              WbValid;
    logic              WbWe;
    logic [4:0]        OpCodeOut;
    logic [6:0]        RdOutOut;
    logic [DATA_W-1:0] WbData;
    logic              MemErr;

    modport master (
        input  InValid, OpCode, RdOut, AluResult, StoreData,
        input  MemAck, MemRData,
        output Stall, MemReq, MemWe, MemAddr, MemWData,
        output WbValid, WbWe, OpCodeOut, RdOutOut, WbData, MemErr
    );

    modport slave (
        output InValid, OpCode, RdOut, AluResult, StoreData,
        output MemAck, MemRData,
        input  Stall, MemReq, MemWe, MemAddr, MemWData,
        input  WbValid, WbWe, OpCodeOut, RdOutOut, WbData, MemErr
    );

endinterface

// File: rtl/mem_req_timer.sv
// Saturating REQ-residency counter.
// expired fires on the cycle whose update brings the count to TIMEOUT.
module mem_req_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt_d == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: memory request/ack handling and registered retire.
// All outputs are flops so the MEM/WB boundary is fully registered.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.master bus
);

    mem_state_t        state_q, state_d;
    logic              stall_q, stall_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]        op_q, op_d;
    logic [6:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        op_out_q, op_out_d;
    logic [6:0]        rd_out_q, rd_out_d;
    logic              mem_err_q, mem_err_d;

    logic tmr_clear;
    logic tmr_en;
    logic tmr_expired;

    mem_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        stall_d     = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        op_d        = op_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_data_d   = wb_data_q;
        op_out_d    = op_out_q;
        rd_out_d    = rd_out_q;
        mem_err_d   = 1'b0;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.InValid) begin
                    if (is_mem_op(bus.OpCode)) begin
                        state_d     = REQ;
                        stall_d     = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (bus.OpCode == OP_STORE);
                        mem_addr_d  = bus.AluResult;
                        mem_wdata_d = bus.StoreData;
                        op_d        = bus.OpCode;
                        rd_d        = bus.RdOut;
                        tmr_clear   = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (bus.OpCode != OP_NOP);
                        wb_data_d  = bus.AluResult;
                        op_out_d   = bus.OpCode;
                        rd_out_d   = bus.RdOut;
                    end
                end
            end
            REQ: begin
                tmr_en = !bus.MemAck;
                // Ack takes priority over a timeout landing on the same edge.
                if (bus.MemAck) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !mem_we_q;
                    wb_data_d  = mem_we_q ? '0 : bus.MemRData;
                    op_out_d   = op_q;
                    rd_out_d   = rd_q;
                end else if (tmr_expired) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    op_out_d   = op_q;
                    rd_out_d   = rd_q;
                    mem_err_d  = 1'b1;
                end else begin
                    stall_d   = 1'b1;
                    mem_req_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= '0;
            op_out_q    <= '0;
            rd_out_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_data_q   <= wb_data_d;
            op_out_q    <= op_out_d;
            rd_out_q    <= rd_out_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus.Stall     = stall_q;
    assign bus.MemReq    = mem_req_q;
    assign bus.MemWe     = mem_we_q;
    assign bus.MemAddr   = mem_addr_q;
    assign bus.MemWData  = mem_wdata_q;
    assign bus.WbValid   = wb_valid_q;
    assign bus.WbWe      = wb_we_q;
    assign bus.WbData    = wb_data_q;
    assign bus.OpCodeOut = op_out_q;
    assign bus.RdOutOut  = rd_out_q;
    assign bus.MemErr    = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Stimulus pushes expected retirements; a negedge monitor pops and compares.
module tb_mem_access_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [4:0]  op;
        logic [6:0]  rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_access_stage_if #(.DATA_W(32)) bi();

    mem_access_stage #(
        .DATA_W  (32),
        .TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_a;
    int   n_chk = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;

    bit          ack_en = 1'b1;
    bit          stray = 1'b0;
    int          ack_delay = 0;
    logic [31:0] rdata = 32'h0;
    int          req_cnt = 0;

    function automatic exp_t mk(input logic we, input logic [31:0] data,
                                input logic [4:0] op, input logic [6:0] rd,
                                input logic err);
        exp_t e;
        e.we = we;
        e.data = data;
        e.op = op;
        e.rd = rd;
        e.err = err;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks after ack_delay REQ cycles; junk data otherwise.
    initial begin
        bi.MemAck = 1'b0;
        bi.MemRData = 32'h0;
        forever begin
            @(negedge clk);
            if (bi.MemReq) begin
                bi.MemAck = ack_en && (req_cnt == ack_delay);
                bi.MemRData = bi.MemAck ? rdata : 32'hBAD0BAD0;
                req_cnt++;
            end else begin
                bi.MemAck = stray;
                bi.MemRData = 32'hBAD1BAD1;
                req_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bi.Stall) stall_cnt++;
    end

    always @(negedge clk) begin
        if (bi.WbValid) begin
            n_chk++;
            mon_a = mk(bi.WbWe, bi.WbData, bi.OpCodeOut, bi.RdOutOut,
                       bi.MemErr);
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL retire_unexpected: got %h expected none",
                         mon_a);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL retire rd=%h: got %h expected %h",
                             mon_e.rd, mon_a, mon_e);
                end
            end
        end else if (bi.MemErr) begin
            n_chk++;
            n_fail++;
            $display("FAIL memerr_alone: got MemErr=1 expected 0");
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [4:0] op, input logic [6:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input exp_t e, input bit push);
        bit ok;
        bit st;
        ok = 1'b0;
        bi.InValid = 1'b1;
        bi.OpCode = op;
        bi.RdOut = rd;
        bi.AluResult = alu;
        bi.StoreData = sd;
        for (int i = 0; i < 100; i++) begin
            st = bi.Stall;
            @(posedge clk);
            if (!st) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            if (push) sb.push_back(e);
            @(negedge clk);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout rd=%h: got stalled expected accept",
                     rd);
        end
    endtask

    initial begin
        bi.InValid = 1'b1;
        bi.OpCode = OP_LOAD;
        bi.RdOut = 7'h03;
        bi.AluResult = 32'h40;
        bi.StoreData = 32'h0;

        // Reset while a load is presented.
        @(negedge clk);
        chk("reset_ctrl", 64'({bi.Stall, bi.MemReq, bi.MemWe, bi.WbValid,
                               bi.WbWe, bi.MemErr, bi.OpCodeOut,
                               bi.RdOutOut}), 64'd0);
        chk("reset_mem_bus", {bi.MemAddr, bi.MemWData}, 64'd0);
        chk("reset_wbdata", 64'(bi.WbData), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bi.InValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_req", 64'(bi.MemReq), 64'd0);
        end

        // Pass-through and NOP.
        send(5'b00011, 7'h05, 32'h1234, 32'h0,
             mk(1'b1, 32'h1234, 5'b00011, 7'h05, 1'b0), 1'b1);
        bi.InValid = 1'b0;
        chk("pass_stall", 64'(bi.Stall), 64'd0);
        chk("pass_wbvalid", 64'(bi.WbValid), 64'd1);
        send(OP_NOP, 7'h06, 32'h55, 32'h0,
             mk(1'b0, 32'h55, OP_NOP, 7'h06, 1'b0), 1'b1);
        bi.InValid = 1'b0;
        @(negedge clk);

        // Load acked in the 4th REQ cycle, with a bundle held behind it.
        ack_en = 1'b1;
        ack_delay = 3;
        rdata = 32'hDEADBEEF;
        stall_cnt = 0;
        send(OP_LOAD, 7'h11, 32'h40, 32'h0,
             mk(1'b1, 32'hDEADBEEF, OP_LOAD, 7'h11, 1'b0), 1'b1);
        chk("load_addr", 64'(bi.MemAddr), 64'h40);
        chk("load_we", 64'(bi.MemWe), 64'd0);
        send(5'b00011, 7'h12, 32'h777, 32'h0,
             mk(1'b1, 32'h777, 5'b00011, 7'h12, 1'b0), 1'b1);
        bi.InValid = 1'b0;
        chk("held_retire", 64'({bi.WbValid, bi.RdOutOut}), 64'h92);
        repeat (2) @(negedge clk);
        chk("load_stall_cycles", 64'(stall_cnt), 64'd4);

        // Store with immediate ack; read data must not leak into WbData.
        ack_delay = 0;
        rdata = 32'h12345678;
        send(OP_STORE, 7'h13, 32'h80, 32'hCAFE,
             mk(1'b0, 32'h0, OP_STORE, 7'h13, 1'b0), 1'b1);
        bi.InValid = 1'b0;
        chk("store_req", 64'(bi.MemReq), 64'd1);
        chk("store_we", 64'(bi.MemWe), 64'd1);
        chk("store_addr", 64'(bi.MemAddr), 64'h80);
        chk("store_wdata", 64'(bi.MemWData), 64'hCAFE);
        repeat (3) @(negedge clk);

        // Timeout after 15 REQ cycles, then stray acks in IDLE.
        ack_en = 1'b0;
        stall_cnt = 0;
        send(OP_LOAD, 7'h14, 32'h44, 32'h0,
             mk(1'b0, 32'h0, OP_LOAD, 7'h14, 1'b1), 1'b1);
        bi.InValid = 1'b0;
        repeat (20) @(negedge clk);
        chk("timeout_stall_cycles", 64'(stall_cnt), 64'd15);
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_no_req", 64'(bi.MemReq), 64'd0);
        end
        stray = 1'b0;
        repeat (2) @(negedge clk);

        // Ack on the same edge the counter would expire: ack wins.
        ack_en = 1'b1;
        ack_delay = 14;
        rdata = 32'h600DF00D;
        stall_cnt = 0;
        send(OP_LOAD, 7'h15, 32'h48, 32'h0,
             mk(1'b1, 32'h600DF00D, OP_LOAD, 7'h15, 1'b0), 1'b1);
        bi.InValid = 1'b0;
        repeat (20) @(negedge clk);
        chk("ack_at_limit_stall", 64'(stall_cnt), 64'd15);

        // Reset in the 2nd REQ cycle: no retire, no error.
        ack_en = 1'b0;
        send(OP_LOAD, 7'h16, 32'h4C, 32'h0,
             mk(1'b0, 32'h0, OP_LOAD, 7'h16, 1'b0), 1'b0);
        bi.InValid = 1'b0;
        @(negedge clk);
        chk("req_second_cycle", 64'(bi.MemReq), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_req", 64'({bi.MemReq, bi.Stall, bi.WbValid, bi.MemErr}),
            64'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_idle", 64'({bi.MemReq, bi.MemErr}), 64'd0);
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
